// File: rtl/key_input_conditioner.sv
// Keypad conditioner: two-flop synchronizer, per-key sampled debounce and
// press/release/long-press pulse generation with a registered any-key flag.
module key_input_conditioner #(
  parameter int N_KEYS       = 12,
  parameter int DB_SAMPLES   = 8,
  parameter int LONG_SAMPLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_sample,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              key_any
);

  localparam int              CW       = $clog2(DB_SAMPLES + 1);
  localparam logic [CW-1:0]   DB_LAST  = CW'(DB_SAMPLES - 1);
  localparam logic [CW-1:0]   DB_ONE   = CW'(1);
  localparam logic [CW-1:0]   DB_ZERO  = CW'(0);
  localparam logic [15:0]     LONG_MAX = 16'(LONG_SAMPLES);
  localparam logic [15:0]     LONG_PRE = 16'(LONG_SAMPLES - 1);

  logic [N_KEYS-1:0]          sync1_q;
  logic [N_KEYS-1:0]          sync2_q;

  logic [N_KEYS-1:0][CW-1:0]  db_cnt_q;
  logic [N_KEYS-1:0][CW-1:0]  db_cnt_d;
  logic [N_KEYS-1:0][15:0]    hold_q;
  logic [N_KEYS-1:0][15:0]    hold_d;
  logic [N_KEYS-1:0]          level_q;
  logic [N_KEYS-1:0]          level_d;
  logic [N_KEYS-1:0]          press_q;
  logic [N_KEYS-1:0]          press_d;
  logic [N_KEYS-1:0]          release_q;
  logic [N_KEYS-1:0]          release_d;
  logic [N_KEYS-1:0]          long_q;
  logic [N_KEYS-1:0]          long_d;
  logic                       any_q;
  logic                       any_d;

  // Two-flop synchronizer for the asynchronous raw key lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce, hold counting and single-cycle event pulses.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (tick_sample) begin
        if (sync2_q[k] == level_q[k]) begin
          db_cnt_d[k] = DB_ZERO;
        end else if (db_cnt_q[k] == DB_LAST) begin
          db_cnt_d[k]  = DB_ZERO;
          level_d[k]   = ~level_q[k];
          press_d[k]   = ~level_q[k];
          release_d[k] = level_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_ONE;
        end

        // A release clears the hold count and wins over a coincident long pulse.
        if (!level_q[k]) begin
          hold_d[k] = 16'd0;
        end else if (!level_d[k]) begin
          hold_d[k] = 16'd0;
        end else if (hold_q[k] < LONG_MAX) begin
          hold_d[k] = hold_q[k] + 16'd1;
          long_d[k] = (hold_q[k] == LONG_PRE);
        end else begin
          hold_d[k] = hold_q[k];
        end
      end else begin
        db_cnt_d[k] = db_cnt_q[k];
        hold_d[k]   = hold_q[k];
      end
    end
    any_d = |level_d;
  end

  // Conditioner state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q  <= '0;
      hold_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      any_q     <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      any_q     <= any_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_any     = any_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: directed scenarios plus random stimulus,
// every cycle compared against a sample-counting reference model.
module tb_key_input_conditioner;

  localparam int N    = 12;
  localparam int DB   = 8;
  localparam int LONG = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic [N-1:0] raw = '0;
  logic [N-1:0] key_level, key_press, key_release, key_long;
  logic         key_any;

  key_input_conditioner #(.N_KEYS(N), .DB_SAMPLES(DB), .LONG_SAMPLES(LONG)) dut (
    .clk(clk), .rst(rst), .tick_sample(tick), .key_raw(raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_any(key_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;
  logic         e_any = 1'b0;
  int           m_run[N];
  int           m_held[N];
  int           n_press[N], n_rel[N], n_long[N];

  task automatic clear_counts();
    for (int k = 0; k < N; k++) begin
      n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0;
    end
  endtask

  // Predict the outputs after the coming rising edge.
  task automatic model_edge();
    logic old, rel;
    e_press = '0; e_release = '0; e_long = '0;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; e_level = '0; e_any = 1'b0;
      for (int k = 0; k < N; k++) begin m_run[k] = 0; m_held[k] = 0; end
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (tick) begin
        old = e_level[k];
        rel = 1'b0;
        if (m_s2[k] == old) m_run[k] = 0;
        else begin
          m_run[k]++;
          if (m_run[k] >= DB) begin
            m_run[k] = 0;
            e_level[k] = ~old;
            if (old) begin e_release[k] = 1'b1; rel = 1'b1; end
            else e_press[k] = 1'b1;
          end
        end
        if (rel) m_held[k] = 0;
        else if (old && m_held[k] < LONG) begin
          m_held[k]++;
          if (m_held[k] == LONG) e_long[k] = 1'b1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    e_any = |e_level;
  endtask

  task automatic check_outputs(input string where);
    total++;
    assert (key_level === e_level) else begin bad++; $error("FAIL level@%s obs=%h exp=%h", where, key_level, e_level); end
    total++;
    assert (key_press === e_press) else begin bad++; $error("FAIL press@%s obs=%h exp=%h", where, key_press, e_press); end
    total++;
    assert (key_release === e_release) else begin bad++; $error("FAIL release@%s obs=%h exp=%h", where, key_release, e_release); end
    total++;
    assert (key_long === e_long) else begin bad++; $error("FAIL long@%s obs=%h exp=%h", where, key_long, e_long); end
    total++;
    assert (key_any === e_any) else begin bad++; $error("FAIL any@%s obs=%b exp=%b", where, key_any, e_any); end
    for (int k = 0; k < N; k++) begin
      n_press[k] += int'(key_press[k]);
      n_rel[k]   += int'(key_release[k]);
      n_long[k]  += int'(key_long[k]);
    end
  endtask

  task automatic step(input string where);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs(where);
  endtask

  task automatic ticks(input int n, input int gap, input string where);
    for (int i = 0; i < n; i++) begin
      tick = 1'b0;
      for (int j = 0; j < gap - 1; j++) step(where);
      tick = 1'b1;
      step(where);
      tick = 1'b0;
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin bad++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp); end
  endtask

  logic [N-1:0] snap_level;
  int           pulses;

  initial begin
    for (int k = 0; k < N; k++) begin m_run[k] = 0; m_held[k] = 0; end
    clear_counts();

    // reset state
    rst = 1'b0; raw = '1; tick = 1'b1;
    repeat (4) step("reset");
    raw = '0; tick = 1'b0;
    rst = 1'b1;
    repeat (3) step("post_reset");

    // key 0 held, slow ticks: press after 8 samples, any asserted
    clear_counts();
    raw[10] = 1'b1;
    ticks(12, 100, "slow_press");
    expect_int("slow_press_count", n_press[10], 1);
    expect_int("slow_level", int'(key_level[10]), 1);
    expect_int("slow_any", int'(key_any), 1);
    raw[10] = 1'b0;
    ticks(12, 5, "slow_release");
    expect_int("slow_release_count", n_rel[10], 1);

    // 7-sample glitch on STAR is rejected
    clear_counts();
    raw[9] = 1'b1;
    ticks(7, 3, "glitch");
    raw[9] = 1'b0;
    ticks(10, 3, "glitch_after");
    expect_int("glitch_press", n_press[9], 0);
    expect_int("glitch_level", int'(key_level[9]), 0);

    // long press on KEY_3
    clear_counts();
    raw[2] = 1'b1;
    ticks(40, 3, "long_hold");
    expect_int("long_press", n_press[2], 1);
    expect_int("long_pulse", n_long[2], 1);
    raw[2] = 1'b0;
    ticks(12, 3, "long_release");
    expect_int("long_release", n_rel[2], 1);
    expect_int("long_after_release", n_long[2], 1);

    // simultaneous press and bouncy line
    clear_counts();
    raw[0] = 1'b1; raw[11] = 1'b1;
    ticks(12, 3, "simul");
    expect_int("simul_p0", n_press[0], 1);
    expect_int("simul_p11", n_press[11], 1);
    for (int i = 0; i < 20; i++) begin
      raw[5] = ~raw[5];
      ticks(1, 3, "bounce");
    end
    raw[5] = 1'b0;
    ticks(10, 3, "bounce_tail");
    expect_int("bounce_press", n_press[5], 0);
    raw[0] = 1'b0; raw[11] = 1'b0;
    ticks(12, 3, "simul_release");

    // reset mid-debounce on KEY_5
    clear_counts();
    raw[4] = 1'b1;
    ticks(5, 3, "mid_db");
    rst = 1'b0;
    #1;
    total++;
    assert ({key_level, key_press, key_release, key_long, key_any} === '0)
      else begin bad++; $error("FAIL async_reset obs=%h exp=0", {key_level, key_press, key_release, key_long, key_any}); end
    @(negedge clk);
    model_edge();
    check_outputs("in_reset0");
    ticks(3, 3, "in_reset");
    rst = 1'b1;
    ticks(5, 3, "after_reset_short");
    expect_int("early_press", n_press[4], 0);
    ticks(7, 3, "after_reset");
    expect_int("reset_press", n_press[4], 1);

    // no tick: outputs frozen despite toggling inputs
    snap_level = e_level;
    clear_counts();
    tick = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      raw = N'($urandom);
      step("no_tick");
    end
    pulses = 0;
    for (int k = 0; k < N; k++) pulses += n_press[k] + n_rel[k] + n_long[k];
    expect_int("no_tick_pulses", pulses, 0);
    total++;
    assert (key_level === snap_level) else begin bad++; $error("FAIL no_tick_level obs=%h exp=%h", key_level, snap_level); end

    // random phase
    for (int i = 0; i < 15000; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 29) == 0) raw[k] = ~raw[k];
      if ($urandom_range(0, 4999) == 0) rst = 1'b0;
      else rst = 1'b1;
      step("random");
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_input_conditioner.md
KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

Interface
REQ-001 The block SHALL expose parameter N_KEYS, default 12, number of keypad lines conditioned.
REQ-002 The block SHALL expose parameter DB_SAMPLES, default 8, consecutive differing samples required to change a debounced level (legal range 2..255).
REQ-003 The block SHALL expose parameter LONG_SAMPLES, default 1000, held samples before the long-press pulse (legal range 2..65535).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 tick_sample  input  1  one-clk sample strobe (1 kHz nominal), from the clock generator.
REQ-007 key_raw  input  N_KEYS  raw active-high key lines, asynchronous to clk; bit 0..8 = KEY_1..KEY_9, bit 9 = KEY_STAR, bit 10 = KEY_0, bit 11 = KEY_SHARP.
REQ-008 key_level  output  N_KEYS  debounced key state, registered.
REQ-009 key_press  output  N_KEYS  one-clk pulse per debounced 0->1 transition.
REQ-010 key_release  output  N_KEYS  one-clk pulse per debounced 1->0 transition.
REQ-011 key_long  output  N_KEYS  one-clk pulse once per hold reaching LONG_SAMPLES.
REQ-012 key_any  output  1  registered OR of key_level.

Function
REQ-013 Each key_raw bit SHALL pass through a 2-flop synchronizer before any other logic; raw-to-synced latency 2 clk.
REQ-014 Each key SHALL hold an independent debounce counter, width ceil(log2(DB_SAMPLES+1)).
REQ-015 Counters and levels SHALL update only on clk edges where tick_sample = 1; with tick_sample = 0 all state except synchronizer and pulse clearing SHALL hold.
REQ-016 On a sample where synced bit equals key_level, the debounce counter SHALL clear to 0.
REQ-017 On a sample where synced bit differs from key_level and counter = DB_SAMPLES-1, key_level SHALL toggle and counter SHALL clear, on that same edge.
REQ-018 On a sample where synced bit differs and counter < DB_SAMPLES-1, counter SHALL increment by 1.
REQ-019 key_press (resp. key_release) SHALL assert on the same edge key_level goes 1 (resp. 0) and deassert on the next clk edge; exactly one clk wide.
REQ-020 Each key SHALL hold a 16-bit hold counter, incremented on each sample while key_level = 1, saturating at LONG_SAMPLES.
REQ-021 key_long SHALL pulse for one clk on the sample edge where hold counter transitions LONG_SAMPLES-1 -> LONG_SAMPLES; no further pulse until a release occurs.
REQ-022 Hold counter SHALL clear on the edge key_level goes 0; key_long SHALL never coincide with key_release.
REQ-023 Keys SHALL be fully independent; simultaneous transitions on any subset SHALL each produce their own pulses on the same edge.
REQ-024 Glitches shorter than DB_SAMPLES consecutive samples SHALL produce no level change and no pulse.
REQ-025 key_any SHALL equal OR of key_level delayed by zero clk (computed from next-state level, registered alongside it).
REQ-026 A key already high at reset release SHALL be treated as a new press: key_level rises and key_press pulses after DB_SAMPLES samples.

Reset
REQ-027 While rst = 0: synchronizers, counters, key_level, key_press, key_release, key_long, key_any SHALL all be 0, immediately and asynchronously.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard progress; no pulse SHALL be emitted on or after reset release for that partial event.
REQ-029 Reset release SHALL be synchronous to clk; first sample counted is the first tick_sample strictly after release edge plus 2 clk.

Verification
REQ-030 Default params, key_raw[10] held 1 with tick every 100 clk -> key_level[10] and key_press[10] rise on 8th tick edge after sync; key_press[10] high exactly 1 clk; key_any = 1.
REQ-031 key_raw[9] pulsed 1 for 7 ticks then 0 -> key_level[9], key_press[9] stay 0 throughout.
REQ-032 LONG_SAMPLES=20, key_raw[2] held 40 ticks -> one key_press, one key_long on 20th held sample, no second key_long; release -> key_release after 8 ticks, no key_long.
REQ-033 key_raw[0] and key_raw[11] asserted same clk -> key_press[0] and key_press[11] pulse on same edge; bouncy input alternating every tick -> no pulse.
REQ-034 rst driven 0 after 5 of 8 samples on key_raw[4], released with key still high -> all outputs 0 during reset; key_press[4] pulses only after 8 further ticks.
REQ-035 tick_sample held 0 for 10000 clk with key_raw toggling -> no change on any output.
